uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the CPU-side write path pushes bytes into a BufferSize-deep FIFO, and a serializer drains it onto tx_sig.
- Frame format: start bit, data bits LSB first, optional parity, stop bits.
- Mirror of the buffered receive path. Sits behind the UART register interface (addr 0x3 write) and replaces the unbuffered transmitter, so back-to-back CPU writes are no longer lost while a frame is in flight.

Parameters:
- BaudRate, 9600, line bit rate.
- ParityBit, 0, 0 = none, 1 = odd, 2 = even.
- DataBitsSize, 8, data bits per frame (5..8).
- StopBitsSize, 1, stop bits per frame (1 or 2).
- BufferSize, 64, FIFO depth in entries; power of two, ≥2.
- ClockFreqHz, 10000000, clk frequency; ClksPerBit = ClockFreqHz/BaudRate (integer divide, must be ≥2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- write_data  input  DataBitsSize  byte to enqueue
- write  input  1  enqueue strobe, one entry per high cycle
- full  output  1  FIFO holds BufferSize entries
- empty  output  1  FIFO holds 0 entries
- count  output  $clog2(BufferSize)+1  current FIFO occupancy
- busy  output  1  serializer not in IDLE
- tx_done  output  1  one-cycle pulse on the final stop-bit cycle of each frame
- tx_sig  output  1  serial line, idle high

Behaviour:
- Reset: one clock clk; reset rst_n is asynchronous, active-low. During reset:
  - tx_sig=1, busy=0, tx_done=0.
  - count=0, empty=1, full=0.
  - FIFO pointers=0, state=IDLE, baud and bit counters=0.
  - A reset mid-frame aborts the frame immediately; tx_sig returns high and FIFO contents are discarded.
- FIFO:
  - Circular buffer with wrapping read/write pointers of width $clog2(BufferSize).
  - full = (count==BufferSize); empty = (count==0); both derived from registered count.
- Write handling:
  - A write while not full is stored at the write pointer, and count increments on the same edge.
  - A write while full and no pop in that cycle is dropped silently; contents and pointers are unchanged.
  - A write and a pop in the same cycle are both performed and count is unchanged. This includes the full case, where the write is accepted.
- Serializer states: IDLE, START, DATA, PARITY, STOP. A baud counter runs 0..ClksPerBit-1 in every non-IDLE state.
- IDLE: if !empty, pop the head into the shift register, compute parity, reset the baud counter, set tx_sig<=0 and go to START. Otherwise tx_sig stays 1.
- START: after ClksPerBit cycles, drive shift[0] and go to DATA.
- DATA:
  - Each bit is held ClksPerBit cycles, then the register shifts right.
  - After DataBitsSize bits, go to PARITY if ParityBit!=0, else STOP.
- PARITY: drive XOR of the data (even) or its inverse (odd) for ClksPerBit cycles.
- STOP: tx_sig=1 for StopBitsSize*ClksPerBit cycles; tx_done pulses on the last of these cycles. On that last cycle:
  - if !empty, pop, go directly to START and set tx_sig<=0 (back-to-back frames, zero idle gap);
  - else go to IDLE.
- Latency: a write registered at edge N to an empty, idle block drives tx_sig low from edge N+1. The start-bit falling edge is therefore one cycle after the write.
- busy = (state != IDLE). Every output is registered.
- Data bits above DataBitsSize are not present; no width truncation occurs inside the block.

Decomposition:
- Shared package uart_pkg holds:
  - typedef tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - parity-mode constants PARITY_NONE/ODD/EVEN;
  - function clks_per_bit(ClockFreqHz, BaudRate).
- One natural sub-module, sync_fifo: a parameterized synchronous FIFO providing push, pop, rdata, count, full and empty. The serializer FSM lives in uart_tx_fifo.

Test Plan:
Bench uses ClockFreqHz=1600, BaudRate=100 (16 clks/bit), BufferSize=4 unless stated.
1. Single byte, no parity: write 0xA5 → tx_sig falls 1 cycle later. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 then a stop of 1. Frame is 160 cycles, one tx_done pulse, busy falls, count returns 0.
2. Back-to-back: write 0x55, 0x0F, 0xFF on consecutive cycles → three contiguous frames with no idle cycle between stop and start, and tx_done pulses exactly 160 cycles apart.
3. Overflow: while frame 1 is sending, write 5 more bytes 0x01..0x05 → the first 4 are queued (full=1) and 0x05 is dropped. Transmitted sequence is frame1, 0x01..0x04.
4. Write on pop while full: make full=1 and issue the write on the STOP→START pop cycle → the write is accepted and count stays 4.
5. Parity: ParityBit=2 with 0x07 → parity bit 1; ParityBit=1 with 0x07 → parity bit 0. With StopBitsSize=2 the stop phase lasts 32 cycles.
6. Reset mid-DATA: assert rst_n=0 during bit 3 → tx_sig=1, busy=0 and count=0 asynchronously, and no further frames are sent after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: serializer state encoding, parity modes and
// the clock-to-baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(input int clock_freq_hz, input int baud_rate);
        return clock_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with a combinational head read and an
// occupancy counter; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: CPU writes queue into sync_fifo, and the frame
// serializer drains it back-to-back onto tx_sig.
module uart_tx_fifo #(
    parameter int BaudRate     = 9600,
    parameter int ParityBit    = 0,
    parameter int DataBitsSize = 8,
    parameter int StopBitsSize = 1,
    parameter int BufferSize   = 64,
    parameter int ClockFreqHz  = 10000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DataBitsSize-1:0]       write_data,
    input  logic                          write,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(BufferSize):0]   count,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          tx_sig
);
    import uart_pkg::*;

    localparam int ClksPerBit = clks_per_bit(ClockFreqHz, BaudRate);
    localparam int BW         = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

    tx_state_e               state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [3:0]              bit_q, bit_d;
    logic [DataBitsSize-1:0] shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    pop;
    logic [DataBitsSize-1:0] head;
    logic                    head_par;
    logic                    baud_last, baud_pre, stop_bit_last;

    sync_fifo #(
        .Width (DataBitsSize),
        .Depth (BufferSize)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (write),
        .wdata (write_data),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head_par      = (ParityBit == PARITY_ODD) ? ~^head : ^head;
    assign baud_last     = (baud_q == BW'(ClksPerBit - 1));
    assign baud_pre      = (baud_q == BW'(ClksPerBit - 2));
    assign stop_bit_last = (bit_q == 4'(StopBitsSize - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == 4'(DataBitsSize - 1)) begin
                        bit_d = '0;
                        if (ParityBit != PARITY_NONE) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                // Registered pulse: raise it one cycle early so it lands on the last stop cycle.
                done_d = baud_pre && stop_bit_last;
                if (baud_last) begin
                    if (stop_bit_last) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_sig  = tx_q;
    assign tx_done = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo at 16 clks/bit: a line monitor decodes
// frames and compares them against bytes queued as they were written.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] write_data;
    logic       write;
    logic       full, empty, busy, tx_done, tx_sig;
    logic [2:0] count;

    logic [7:0] wd_e, wd_o;
    logic       wr_e, wr_o;
    logic       full_e, empty_e, busy_e, done_e, tx_e;
    logic       full_o, empty_o, busy_o, done_o, tx_o;
    logic [2:0] cnt_e, cnt_o;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         frames = 0;
    logic [7:0] exp_q[$];
    int         done_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n && tx_done) done_t.push_back(cyc);

    uart_tx_fifo #(.BaudRate(100), .ParityBit(0), .DataBitsSize(8), .StopBitsSize(1),
                   .BufferSize(4), .ClockFreqHz(1600)) dut (
        .clk(clk), .rst_n(rst_n), .write_data(write_data), .write(write),
        .full(full), .empty(empty), .count(count), .busy(busy),
        .tx_done(tx_done), .tx_sig(tx_sig));

    uart_tx_fifo #(.BaudRate(100), .ParityBit(2), .DataBitsSize(8), .StopBitsSize(2),
                   .BufferSize(4), .ClockFreqHz(1600)) dut_e (
        .clk(clk), .rst_n(rst_n), .write_data(wd_e), .write(wr_e),
        .full(full_e), .empty(empty_e), .count(cnt_e), .busy(busy_e),
        .tx_done(done_e), .tx_sig(tx_e));

    uart_tx_fifo #(.BaudRate(100), .ParityBit(1), .DataBitsSize(8), .StopBitsSize(1),
                   .BufferSize(4), .ClockFreqHz(1600)) dut_o (
        .clk(clk), .rst_n(rst_n), .write_data(wd_o), .write(wr_o),
        .full(full_o), .empty(empty_o), .count(cnt_o), .busy(busy_o),
        .tx_done(done_o), .tx_sig(tx_o));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input bit acc);
        write_data = d;
        write      = 1'b1;
        if (acc) exp_q.push_back(d);
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && empty) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    // Line monitor: frame cycle 0 is the first low sample; bits sampled mid-bit.
    initial begin
        logic [9:0] s;
        logic [7:0] e;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_sig === 1'b0) begin
                ab = 1'b0;
                s  = '0;
                for (int c = 1; c <= 152; c++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    if (c % 16 == 8) s[(c - 8) / 16] = tx_sig;
                end
                if (!ab) begin
                    frames++;
                    if (exp_q.size() == 0) begin
                        chk("frame_unexpected", 32'(s), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", 32'(s), 32'({1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    initial begin
        int w, w0, low, fr0;
        bit seen;
        rst_n = 1'b0; write = 1'b0; write_data = '0;
        wr_e = 1'b0; wd_e = '0; wr_o = 1'b0; wd_o = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_sig), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Parity and stop-length on the side instances, 0x07
        wd_e = 8'h07; wr_e = 1'b1; wd_o = 8'h07; wr_o = 1'b1;
        @(negedge clk);
        wr_e = 1'b0; wr_o = 1'b0;
        for (int c = 0; c <= 192; c++) begin
            @(negedge clk);
            if (c == 0)   chk("par_e_start", 32'(tx_e), 0);
            if (c == 152) chk("par_even", 32'(tx_e), 1);
            if (c == 152) chk("par_odd", 32'(tx_o), 0);
            if (c == 160) chk("stop2_first", 32'(tx_e), 1);
            if (c == 175) chk("done_o_at_175", 32'(done_o), 1);
            if (c == 176) chk("stop2_second", 32'(tx_e), 1);
            if (c == 190) chk("done_e_early", 32'(done_e), 0);
            if (c == 191) chk("done_e_at_191", 32'(done_e), 1);
            if (c == 192) chk("busy_e_fall", 32'(busy_e), 0);
        end

        // Single byte latency and frame length
        done_t.delete();
        wr(8'hA5, 1'b1);
        w = cyc;
        chk("lat_tx_high", 32'(tx_sig), 1);
        chk("lat_count1", 32'(count), 1);
        @(negedge clk);
        chk("lat_tx_low", 32'(tx_sig), 0);
        chk("lat_busy", 32'(busy), 1);
        chk("lat_count0", 32'(count), 0);
        wait_idle(300);
        chk("t1_done_cnt", done_t.size(), 1);
        if (done_t.size() > 0) chk("t1_frame_len", done_t[0] - w, 160);
        chk("t1_count", 32'(count), 0);

        // Back-to-back frames
        done_t.delete();
        wr(8'h55, 1'b1);
        w0 = cyc;
        wr(8'h0F, 1'b1);
        wr(8'hFF, 1'b1);
        wait_idle(700);
        chk("t2_done_cnt", done_t.size(), 3);
        if (done_t.size() == 3) begin
            chk("t2_first", done_t[0] - w0, 160);
            chk("t2_gap1", done_t[1] - done_t[0], 160);
            chk("t2_gap2", done_t[2] - done_t[1], 160);
        end

        // Overflow: fifth write while full is dropped
        wr(8'h11, 1'b1);
        repeat (5) @(negedge clk);
        for (int i = 1; i <= 5; i++) wr(8'(i), i <= 4);
        chk("t3_full", 32'(full), 1);
        chk("t3_count", 32'(count), 4);
        wait_idle(1200);

        // Write on the STOP->START pop cycle while full is accepted
        wr(8'h21, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) wr(8'h30 + 8'(i), 1'b1);
        chk("t4_full", 32'(full), 1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4_done_seen", 32'(seen), 1);
        wr(8'h35, 1'b1);
        chk("t4_count", 32'(count), 4);
        chk("t4_still_full", 32'(full), 1);
        wait_idle(1300);

        // Asynchronous reset mid-DATA discards frame and queue
        wr(8'hC3, 1'b1);
        wr(8'h3C, 1'b1);
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tx", 32'(tx_sig), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        exp_q.delete();
        fr0 = frames;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        low = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx_sig !== 1'b1) low++;
        end
        chk("t6_line_quiet", low, 0);
        chk("t6_no_frames", frames - fr0, 0);
        chk("t6_busy_after", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
